// File: rtl/attenuator_spi_scheduler.sv
// attenuator_spi_scheduler: round-robin arbiter that feeds one SPI serializer
// from NUM_CH attenuator-control requesters. Each grant loads one command word,
// waits for the serializer's end-of-frame pulse (or a timeout), acknowledges
// the requester, then holds off for an inter-frame gap.
module attenuator_spi_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int Register_Width = 32,
  parameter int LD_CYCLES      = 2,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_CH-1:0]                req,
  input  logic [NUM_CH*Register_Width-1:0] req_data,
  output logic [NUM_CH-1:0]                ack,
  output logic                             err_timeout,
  output logic [Register_Width-1:0]        ser_data,
  output logic                             ser_ld,
  input  logic                             ser_cs,
  output logic                             busy,
  output logic [$clog2(NUM_CH)-1:0]        cur_ch
);

  localparam int CH_W    = $clog2(NUM_CH);
  localparam int MAX_TG  = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (MAX_TG > LD_CYCLES) ? MAX_TG : LD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts; the gap terminal is unused when GAP_CYCLES is 0.
  localparam logic [CNT_W-1:0] LD_LAST  = CNT_W'(LD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_GAP
  } state_t;

  state_t                    state_reg, state_next;
  logic [CNT_W-1:0]          cnt_reg, cnt_next;
  logic [NUM_CH-1:0]         ack_reg, ack_next;
  logic                      err_reg, err_next;
  logic [Register_Width-1:0] data_reg, data_next;
  logic [CH_W-1:0]           ch_reg, ch_next;
  logic [CH_W-1:0]           rr_reg, rr_next;

  logic [Register_Width-1:0] words [NUM_CH];
  logic                      pick_valid;
  logic [CH_W-1:0]           pick_ch;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign words[gi] = req_data[gi*Register_Width +: Register_Width];
  end

  // Round-robin pick: first set request at or above the pointer, wrapping.
  // Walking the offsets downward lets the smallest offset win.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[(int'(rr_reg) + i) % NUM_CH]) begin
        pick_valid = 1'b1;
        pick_ch    = CH_W'((int'(rr_reg) + i) % NUM_CH);
      end
    end
  end

  // Next-state logic: sequencing, counter, grant capture and ack generation.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = '0;
    err_next   = 1'b0;
    data_next  = data_reg;
    ch_next    = ch_reg;
    rr_next    = rr_reg;
    case (state_reg)
      // Drain whatever frame the serializer may still be sending after our reset.
      S_INIT: begin
        if (ser_cs || cnt_reg == TO_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (pick_valid) begin
          state_next = S_LOAD;
          cnt_next   = '0;
          data_next  = words[pick_ch];
          ch_next    = pick_ch;
          rr_next    = (pick_ch == LAST_CH) ? '0 : pick_ch + CH_W'(1);
        end
      end
      S_LOAD: begin
        if (cnt_reg == LD_LAST) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      // A completion pulse on the terminal cycle still counts as success.
      S_WAIT: begin
        if (ser_cs || cnt_reg == TO_LAST) begin
          ack_next[ch_reg] = 1'b1;
          err_next         = !ser_cs;
          cnt_next         = '0;
          state_next       = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      // The ack cycle is the first gap cycle.
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      cnt_reg   <= '0;
      ack_reg   <= '0;
      err_reg   <= 1'b0;
      data_reg  <= '0;
      ch_reg    <= '0;
      rr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      data_reg  <= data_next;
      ch_reg    <= ch_next;
      rr_reg    <= rr_next;
    end
  end

  assign ack         = ack_reg;
  assign err_timeout = err_reg;
  assign ser_data    = data_reg;
  assign ser_ld      = (state_reg == S_LOAD);
  assign busy        = (state_reg != S_IDLE);
  assign cur_ch      = ch_reg;

endmodule

// File: tb/tb_attenuator_spi_scheduler.sv
// Testbench for attenuator_spi_scheduler: scoreboard of expected grants and
// acks checked by a negedge monitor, plus per-scenario timing checks.
module tb_attenuator_spi_scheduler;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'h2222_1111;
  localparam logic [31:0] D2 = 32'hA5A5_00FF;
  localparam logic [31:0] D3 = 32'h4444_3333;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   ack;
  logic         err_timeout;
  logic [31:0]  ser_data;
  logic         ser_ld;
  logic         ser_cs;
  logic         busy;
  logic [1:0]   cur_ch;

  // Second build with no inter-frame gap.
  logic [3:0]   req_z;
  logic [3:0]   ack_z;
  logic         err_z;
  logic [31:0]  ser_data_z;
  logic         ser_ld_z;
  logic         ser_cs_z;
  logic         busy_z;
  logic [1:0]   cur_ch_z;

  logic [3:0]   rearm;
  int           checks = 0;
  int           errors = 0;
  logic         ld_prev = 1'b0;

  typedef struct { int ch; logic [31:0] data; } grant_t;
  typedef struct { int ch; logic err; } ack_t;
  grant_t grant_q[$];
  ack_t   ack_q[$];

  always #5 clk = ~clk;

  attenuator_spi_scheduler dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .err_timeout(err_timeout), .ser_data(ser_data), .ser_ld(ser_ld),
    .ser_cs(ser_cs), .busy(busy), .cur_ch(cur_ch)
  );

  attenuator_spi_scheduler #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_z (
    .clk(clk), .rst_n(rst_n), .req(req_z), .req_data(req_data), .ack(ack_z),
    .err_timeout(err_z), .ser_data(ser_data_z), .ser_ld(ser_ld_z),
    .ser_cs(ser_cs_z), .busy(busy_z), .cur_ch(cur_ch_z)
  );

  // Scoreboard monitor: every load start and every ack is matched against the queues.
  always @(negedge clk) begin
    if (ser_ld && !ld_prev) begin
      checks++;
      if (grant_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: cur_ch=%0d ser_data=%h, required no grant", cur_ch, ser_data);
      end else begin
        grant_t g;
        g = grant_q.pop_front();
        if (cur_ch !== 2'(g.ch) || ser_data !== g.data) begin
          errors++;
          $display("FAIL grant: cur_ch=%0d ser_data=%h, required cur_ch=%0d ser_data=%h",
                   cur_ch, ser_data, g.ch, g.data);
        end
      end
    end
    ld_prev = ser_ld;
    if (ack !== 4'b0000) begin
      checks++;
      if (ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: ack=%b err=%b, required no ack", ack, err_timeout);
      end else begin
        ack_t a;
        logic [3:0] exp_ack;
        a = ack_q.pop_front();
        exp_ack = 4'(1 << a.ch);
        if (ack !== exp_ack || err_timeout !== a.err) begin
          errors++;
          $display("FAIL ack: ack=%b err=%b, required ack=%b err=%b", ack, err_timeout, exp_ack, a.err);
        end
      end
    end else if (err_timeout !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL err_alone: err_timeout=%b without ack, required 0", err_timeout);
    end
  end

  // Wait for a load to start and finish, delay, pulse ser_cs, then release acked requests.
  task automatic serve(input int delay);
    int n;
    n = 0;
    while (ser_ld !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (ser_ld === 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL serve_bound: ser_ld never completed a load, waited %0d cycles", n);
    end
    repeat (delay) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    req = req & ~(ack & ~rearm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 4'b0 || err_timeout !== 1'b0 || ser_ld !== 1'b0 || ser_data !== 32'h0 ||
        busy !== 1'b1 || cur_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: ack=%b err=%b ld=%b data=%h busy=%b ch=%0d, required 0 0 0 0 1 0",
               ack, err_timeout, ser_ld, ser_data, busy, cur_ch);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL init_cs_exit: busy=%b, required 0", busy);
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2047) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL init_early_exit: busy=%b after 2047 cycles, required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0 || ser_ld !== 1'b0 || ser_data !== 32'h0) begin
      errors++;
      $display("FAIL init_timeout_exit: busy=%b ack=%b ld=%b data=%h, required 0 0 0 0",
               busy, ack, ser_ld, ser_data);
    end
  endtask

  task automatic test_single();
    int n;
    grant_q.push_back('{2, D2});
    ack_q.push_back('{2, 1'b0});
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (ser_ld !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: ser_ld=%b one cycle after request, required 1", ser_ld);
    end
    n = 0;
    while (ser_ld === 1'b1 && n < 10) begin n++; @(negedge clk); end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL single_ld_len: ser_ld high %0d cycles, required 2", n);
    end
    repeat (39) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    checks++;
    if (ack !== 4'b0100 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: ack=%b err=%b, required 0100 0", ack, err_timeout);
    end
    grant_q.push_back('{3, D3});
    ack_q.push_back('{3, 1'b0});
    req = 4'b1000;
    @(negedge clk);
    n = 1;
    checks++;
    if (ack !== 4'b0000) begin
      errors++;
      $display("FAIL single_ack_width: ack=%b one cycle later, required 0000", ack);
    end
    while (ser_ld !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (n != 17) begin
      errors++;
      $display("FAIL single_gap: next ser_ld %0d cycles after ack, required 17", n);
    end
    serve(2);
  endtask

  task automatic test_round_robin();
    grant_q.push_back('{0, D0}); ack_q.push_back('{0, 1'b0});
    grant_q.push_back('{1, D1}); ack_q.push_back('{1, 1'b0});
    grant_q.push_back('{2, D2}); ack_q.push_back('{2, 1'b0});
    grant_q.push_back('{3, D3}); ack_q.push_back('{3, 1'b0});
    grant_q.push_back('{0, D0}); ack_q.push_back('{0, 1'b0});
    rearm = 4'b1111;
    req = 4'b1111;
    repeat (4) serve(3);
    rearm = 4'b0000;
    serve(3);
    req = 4'b0000;
    grant_q.push_back('{3, D3}); ack_q.push_back('{3, 1'b0});
    grant_q.push_back('{0, D0}); ack_q.push_back('{0, 1'b0});
    req = 4'b1001;
    serve(3);
    serve(3);
    checks++;
    if (req !== 4'b0000) begin
      errors++;
      $display("FAIL rr_drain: outstanding req=%b, required 0000", req);
    end
  endtask

  task automatic test_timeout();
    int n;
    grant_q.push_back('{1, D1});
    ack_q.push_back('{1, 1'b1});
    req = 4'b0010;
    n = 0;
    while (ser_ld !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (ser_ld === 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (2047) @(negedge clk);
    checks++;
    if (ack !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_early: ack=%b at 2047 cycles, required 0000", ack);
    end
    @(negedge clk);
    checks++;
    if (ack !== 4'b0010 || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ack: ack=%b err=%b at 2048 cycles, required 0010 1", ack, err_timeout);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_width: err_timeout=%b, required 0", err_timeout);
    end
    grant_q.push_back('{2, D2});
    ack_q.push_back('{2, 1'b0});
    req = 4'b0100;
    serve(5);
  endtask

  task automatic test_boundary();
    int n;
    grant_q.push_back('{0, D0});
    ack_q.push_back('{0, 1'b0});
    req = 4'b0001;
    n = 0;
    while (ser_ld !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    while (ser_ld === 1'b1 && n < 50) begin @(negedge clk); n++; end
    repeat (2047) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    checks++;
    if (ack !== 4'b0001 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL boundary_last_cycle: ack=%b err=%b, required 0001 0", ack, err_timeout);
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL boundary_cs_in_gap: ack=%b busy=%b, required 0000 1", ack, busy);
    end
    repeat (20) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL boundary_cs_in_idle: ack=%b busy=%b, required 0000 0", ack, busy);
    end
  endtask

  task automatic test_reset_load();
    int n;
    grant_q.push_back('{3, D3});
    req = 4'b1000;
    n = 0;
    while (ser_ld !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (ser_ld !== 1'b1) begin
      errors++;
      $display("FAIL reset_load_second_cycle: ser_ld=%b, required 1", ser_ld);
    end
    rst_n = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (ser_ld !== 1'b0 || busy !== 1'b1 || ack !== 4'b0000) begin
      errors++;
      $display("FAIL reset_load: ld=%b busy=%b ack=%b, required 0 1 0000", ser_ld, busy, ack);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ser_cs = 1'b1;
    @(negedge clk);
    ser_cs = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ack !== 4'b0000 || cur_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_load_recover: busy=%b ack=%b ch=%0d, required 0 0000 0", busy, ack, cur_ch);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    req_z = 4'b0001;
    n = 0;
    while (ser_ld_z !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (ser_ld_z === 1'b1 && n < 200) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    ser_cs_z = 1'b1;
    @(negedge clk);
    ser_cs_z = 1'b0;
    checks++;
    if (ack_z !== 4'b0001 || err_z !== 1'b0) begin
      errors++;
      $display("FAIL gap0_ack: ack=%b err=%b, required 0001 0", ack_z, err_z);
    end
    req_z = 4'b0010;
    @(negedge clk);
    checks++;
    if (ser_ld_z !== 1'b1 || cur_ch_z !== 2'd1 || ser_data_z !== D1) begin
      errors++;
      $display("FAIL gap0_b2b: ld=%b ch=%0d data=%h, required 1 1 %h", ser_ld_z, cur_ch_z, ser_data_z, D1);
    end
    while (ser_ld_z === 1'b1 && n < 400) begin @(negedge clk); n++; end
    ser_cs_z = 1'b1;
    @(negedge clk);
    ser_cs_z = 1'b0;
    checks++;
    if (ack_z !== 4'b0010) begin
      errors++;
      $display("FAIL gap0_second_ack: ack=%b, required 0010", ack_z);
    end
    req_z = 4'b0000;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_z    = 4'b0000;
    ser_cs   = 1'b0;
    ser_cs_z = 1'b0;
    rearm    = 4'b0000;
    req_data = {D3, D2, D1, D0};
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_boundary();
    test_reset_load();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (grant_q.size() != 0 || ack_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d grants and %0d acks outstanding, required 0 and 0",
               grant_q.size(), ack_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/attenuator_spi_scheduler.md
# attenuator_spi_scheduler

Round-robin scheduler that shares one SPI serializer between several attenuator-control requesters on the ZCU111 daughter-board path. It captures one command word per granted requester and drives the serializer's parallel load strobe. It detects end of frame from the serializer's one-cycle CS completion pulse and enforces a programmable inter-frame gap. It also recovers from a hung serializer with a timeout.

## Interface
- NUM_CH, 4: number of requesters (≥2).
- Register_Width, 32: command word width; matches serializer data register.
- LD_CYCLES, 2: cycles ser_ld is held high per frame (≥1).
- GAP_CYCLES, 16: idle cycles between frames (0 allowed).
- TIMEOUT_CYCLES, 2048: max cycles to wait for completion pulse (≥2).
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  NUM_CH  per-channel request level; held high until matching ack.
- req_data  input  NUM_CH*Register_Width  channel i word at bits [i*Register_Width +: Register_Width]; stable while req[i] high.
- ack  output  NUM_CH  one-cycle one-hot pulse: frame for that channel finished (success or timeout).
- err_timeout  output  1  one-cycle pulse coincident with ack when frame timed out.
- ser_data  output  Register_Width  word presented to serializer.
- ser_ld  output  1  serializer load strobe.
- ser_cs  input  1  serializer completion pulse (one clk cycle high at end of frame).
- busy  output  1  high in every state except IDLE.
- cur_ch  output  $clog2(NUM_CH)  channel currently/last granted.

## Operation
- States: INIT, IDLE, LOAD, WAIT, GAP.
- Reset (rst_n=0 at edge): state INIT; ack=0, err_timeout=0, ser_ld=0, ser_data=0, busy=1, cur_ch=0, rr pointer=0, all counters 0.
- INIT: serializer is not reset by this block, so drain any in-flight frame. Leave on ser_cs=1 or after TIMEOUT_CYCLES cycles → IDLE. No ack issued.
- IDLE: if any req bit set, pick first set bit searching from rr pointer upward with wrap. Latch its word into ser_data, set cur_ch, go LOAD. rr pointer ← granted+1 mod NUM_CH.
- LOAD: ser_ld=1 for exactly LD_CYCLES cycles, ser_data stable; then WAIT with ser_ld=0.
- WAIT: count cycles from 0.
  - ser_cs=1 → ack[cur_ch] pulse next cycle, go GAP.
  - Count reaches TIMEOUT_CYCLES-1 without ser_cs → ack[cur_ch] and err_timeout pulse next cycle, go GAP.
  - ser_cs on the timeout cycle counts as success.
- GAP: GAP_CYCLES cycles then IDLE; GAP_CYCLES=0 → IDLE directly after the ack cycle.
- ser_data holds last word until next grant. ser_cs outside WAIT/INIT is ignored.
- req[i] dropped after grant: frame still completes, ack[i] still pulsed. A requester must not reassert before its ack, or it gets a duplicate frame.
- Counters sized $clog2(max(TIMEOUT_CYCLES,GAP_CYCLES,LD_CYCLES)+1); no wrap possible.

## Timing
- req sampled high in IDLE at edge N → LOAD from N+1; ser_ld high N+1..N+LD_CYCLES; WAIT from N+LD_CYCLES+1.
- ser_cs high at edge M in WAIT → ack high for cycle M+1 only, GAP from M+1.
- Next grant earliest at edge M+1+GAP_CYCLES (IDLE evaluation), i.e. ser_ld re-asserts at M+2+GAP_CYCLES.
- Timeout: ack/err at WAIT entry + TIMEOUT_CYCLES.
- Reset mid-frame: ser_ld drops at the reset edge; in-flight channel gets no ack; the channel must re-request.
- Simultaneous requests: at most one grant per IDLE visit; with all NUM_CH requesting continuously, each is served once per NUM_CH frames.

## Test plan
- Reset: hold rst_n=0 3 cycles, pulse ser_cs in INIT → IDLE next cycle. With no ser_cs, IDLE reached after 2048 cycles, outputs all 0, busy 1→0.
- Single request: req=4'b0100, req_data[2]=32'hA5A5_00FF, bench pulses ser_cs 40 cycles after ser_ld falls → ser_data=32'hA5A5_00FF, ser_ld high 2 cycles, ack=4'b0100 one cycle, err_timeout=0, next ser_ld no earlier than 16 cycles after ack.
- Round-robin: req=4'b1111 held, each reasserted after ack → grant order 0,1,2,3,0; then req=4'b1001 from pointer 1 → 3 then 0.
- Timeout: never pulse ser_cs → ack plus err_timeout exactly 2048 cycles after WAIT entry; following request served normally.
- Boundary: ser_cs on cycle 2047 of WAIT → success, err_timeout=0. ser_cs pulse during GAP/IDLE → no ack, no state change. GAP_CYCLES=0 build → back-to-back grant one cycle after ack.
- Reset during LOAD: rst_n low in 2nd ld cycle → ser_ld=0 next edge, no ack to that channel, INIT entered.
